// File: rtl/sub_share_arbiter.sv
// rtl/sub_share_arbiter.sv - round-robin shared subtractor for NUM_REQ requesters
// Grants one requester per cycle, registers its extended operands, returns a - b tagged.
module sub_share_arbiter #(
  parameter int    NUM_REQ         = 4,
  parameter int    A_WIDTH         = 4,
  parameter int    B_WIDTH         = 4,
  parameter string A_IS_SIGNED     = "TRUE",
  parameter string B_IS_SIGNED     = "TRUE",
  parameter string REGISTER_OUTPUT = "FALSE",
  localparam int   OUT_WIDTH       = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
  localparam int   TAG_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*A_WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*B_WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         res_valid,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic [OUT_WIDTH-1:0]         res
);

  localparam bit A_SIGNED = (A_IS_SIGNED == "TRUE");
  localparam bit B_SIGNED = (B_IS_SIGNED == "TRUE");
  localparam bit REG_OUT  = (REGISTER_OUTPUT == "TRUE");

  logic [TAG_WIDTH-1:0] ptr;
  logic [TAG_WIDTH-1:0] win;
  logic [TAG_WIDTH-1:0] cand;
  logic                 hit;
  logic                 xfer;
  logic [A_WIDTH-1:0]   a_sel;
  logic [B_WIDTH-1:0]   b_sel;
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;

  logic                 s1_valid;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [OUT_WIDTH-1:0] s1_a;
  logic [OUT_WIDTH-1:0] s1_b;
  logic [OUT_WIDTH-1:0] diff;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = TAG_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  assign xfer  = ce && hit && !rst;
  assign grant = xfer ? (NUM_REQ'(1) << win) : '0;

  assign a_sel = a_in[win*A_WIDTH +: A_WIDTH];
  assign b_sel = b_in[win*B_WIDTH +: B_WIDTH];

  always_comb begin
    a_ext = {{(OUT_WIDTH-A_WIDTH){A_SIGNED & a_sel[A_WIDTH-1]}}, a_sel};
    b_ext = {{(OUT_WIDTH-B_WIDTH){B_SIGNED & b_sel[B_WIDTH-1]}}, b_sel};
  end

  // Operand registers only load on a transfer, so res/res_tag hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (ce) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_tag <= win;
        s1_a   <= a_ext;
        s1_b   <= b_ext;
        ptr    <= (win == TAG_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign diff = s1_a - s1_b;

  generate
    if (REG_OUT) begin : g_reg_out
      logic                 o_valid;
      logic [TAG_WIDTH-1:0] o_tag;
      logic [OUT_WIDTH-1:0] o_res;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          o_valid <= 1'b0;
          o_tag   <= '0;
          o_res   <= '0;
        end else if (ce) begin
          o_valid <= s1_valid;
          if (s1_valid) begin
            o_tag <= s1_tag;
            o_res <= diff;
          end
        end
      end

      assign res_valid = o_valid;
      assign res_tag   = o_tag;
      assign res       = o_res;
    end else begin : g_comb_out
      assign res_valid = s1_valid;
      assign res_tag   = s1_tag;
      assign res       = diff;
    end
  endgenerate

endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb/tb_sub_share_arbiter.sv - directed bench for sub_share_arbiter
// Three instances share stimulus: signed/comb out, unsigned/comb out, signed/registered out.
module tb_sub_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [3:0]  req;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic [3:0] grant_s, grant_u, grant_r;
  logic       vld_s, vld_u, vld_r;
  logic [1:0] tag_s, tag_u, tag_r;
  logic [4:0] res_s, res_u, res_r;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_s [4];
  logic [4:0] exp_u [4];

  always #5 clk = ~clk;

  sub_share_arbiter #(.NUM_REQ(4), .A_WIDTH(4), .B_WIDTH(4),
    .A_IS_SIGNED("TRUE"), .B_IS_SIGNED("TRUE"), .REGISTER_OUTPUT("FALSE")) u_s (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant_s), .res_valid(vld_s), .res_tag(tag_s), .res(res_s));

  sub_share_arbiter #(.NUM_REQ(4), .A_WIDTH(4), .B_WIDTH(4),
    .A_IS_SIGNED("FALSE"), .B_IS_SIGNED("FALSE"), .REGISTER_OUTPUT("FALSE")) u_u (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant_u), .res_valid(vld_u), .res_tag(tag_u), .res(res_u));

  sub_share_arbiter #(.NUM_REQ(4), .A_WIDTH(4), .B_WIDTH(4),
    .A_IS_SIGNED("TRUE"), .B_IS_SIGNED("TRUE"), .REGISTER_OUTPUT("TRUE")) u_r (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant_r), .res_valid(vld_r), .res_tag(tag_r), .res(res_r));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One granted cycle: requester i wins now; prev is what the registered instance shows after the edge.
  task automatic xfer(input int i, input int prev);
    #1;
    check("grant_s", 32'(grant_s), 32'(1 << i));
    check("grant_u", 32'(grant_u), 32'(1 << i));
    check("grant_r", 32'(grant_r), 32'(1 << i));
    step();
    check("vld_s", 32'(vld_s), 32'd1);
    check("tag_s", 32'(tag_s), 32'(i));
    check("res_s", 32'(res_s), 32'(exp_s[i]));
    check("vld_u", 32'(vld_u), 32'd1);
    check("res_u", 32'(res_u), 32'(exp_u[i]));
    if (prev >= 0) begin
      check("vld_r", 32'(vld_r), 32'd1);
      check("tag_r", 32'(tag_r), 32'(prev));
      check("res_r", 32'(res_r), 32'(exp_s[prev]));
    end
  endtask

  initial begin
    rst  = 1'b1;
    ce   = 1'b1;
    req  = 4'b1111;
    a_in = {4'd5, 4'b1000, 4'd6, 4'd7};
    b_in = {4'd2, 4'b0111, 4'd1, 4'b1000};
    exp_s[0] = 5'b01111; exp_s[1] = 5'b00101; exp_s[2] = 5'b10001; exp_s[3] = 5'b00011;
    exp_u[0] = 5'b11111; exp_u[1] = 5'b00101; exp_u[2] = 5'b00001; exp_u[3] = 5'b00011;

    step();
    step();
    check("rst_grant", 32'(grant_s), 32'd0);
    check("rst_vld_s", 32'(vld_s), 32'd0);
    check("rst_tag_s", 32'(tag_s), 32'd0);
    check("rst_res_s", 32'(res_s), 32'd0);
    check("rst_vld_r", 32'(vld_r), 32'd0);
    check("rst_res_r", 32'(res_r), 32'd0);
    rst = 1'b0;

    // Round robin with all four requesting.
    for (int c = 0; c < 8; c++)
      xfer(c % 4, (c == 0) ? -1 : (c - 1) % 4);

    // ce stall mid-stream.
    xfer(0, 3);
    xfer(1, 0);
    ce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_grant", 32'(grant_s), 32'd0);
      step();
      check("stall_vld_s", 32'(vld_s), 32'd1);
      check("stall_tag_s", 32'(tag_s), 32'd1);
      check("stall_res_s", 32'(res_s), 32'(exp_s[1]));
      check("stall_vld_r", 32'(vld_r), 32'd1);
      check("stall_tag_r", 32'(tag_r), 32'd0);
    end
    ce = 1'b1;
    xfer(2, 1);
    xfer(3, 2);
    xfer(0, 3);
    xfer(1, 0);
    xfer(2, 1);

    // Pointer at 3 with req=1001, new unsigned-wrap operands on requester 0.
    req = 4'b1001;
    a_in[3:0] = 4'd0;
    b_in[3:0] = 4'd15;
    exp_s[0] = 5'b00001;
    exp_u[0] = 5'b10001;
    xfer(3, 2);
    xfer(0, 3);

    // Idle: strobes drop, data holds.
    req = 4'b0000;
    #1;
    check("idle_grant", 32'(grant_s), 32'd0);
    step();
    check("idle_vld_s", 32'(vld_s), 32'd0);
    check("idle_tag_s", 32'(tag_s), 32'd0);
    check("idle_res_u", 32'(res_u), 32'(exp_u[0]));
    check("idle_vld_r", 32'(vld_r), 32'd1);
    check("idle_res_r", 32'(res_r), 32'(exp_s[0]));
    step();
    check("idle_vld_r2", 32'(vld_r), 32'd0);

    // Single requester granted every cycle.
    req = 4'b0100;
    xfer(2, -1);
    xfer(2, 2);
    xfer(2, 2);

    // Reset one cycle after a transfer discards it.
    req = 4'b0001;
    xfer(0, 2);
    req = 4'b0000;
    rst = 1'b1;
    #1;
    check("mrst_vld_s", 32'(vld_s), 32'd0);
    check("mrst_vld_r", 32'(vld_r), 32'd0);
    check("mrst_res_r", 32'(res_r), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("mrst_vld_r2", 32'(vld_r), 32'd0);
    req = 4'b1111;
    xfer(0, -1);
    xfer(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
